// File: rtl/mux21_sel_arb_if.sv
// Request/grant bundle between the two requesters and mux21_sel_arb.
// Carries the lock input only when MUX21_SEL_LOCK_EN is defined.
interface mux21_sel_arb_if;
    logic req_a;
    logic req_b;
    logic sel;
    logic gnt_a;
    logic gnt_b;
    logic busy;
`ifdef MUX21_SEL_LOCK_EN
    logic lock;
`endif

    modport master (
        output req_a,
        output req_b,
`ifdef MUX21_SEL_LOCK_EN
        output lock,
`endif
        input  sel,
        input  gnt_a,
        input  gnt_b,
        input  busy
    );

    modport slave (
        input  req_a,
        input  req_b,
`ifdef MUX21_SEL_LOCK_EN
        input  lock,
`endif
        output sel,
        output gnt_a,
        output gnt_b,
        output busy
    );
endinterface

// File: rtl/mux21_sel_arb.sv
// Round-robin select/grant controller for a 2:1 mux, burst-limited.
// Optional burst lock input enabled by defining MUX21_SEL_LOCK_EN.
module mux21_sel_arb #(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    mux21_sel_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;

    logic lock_w;
    logic is_idle;
    logic is_own;
    logic cur;
    logic own_req;
    logic oth_req;
    logic at_max;
    state_t other_st;

`ifdef MUX21_SEL_LOCK_EN
    assign lock_w = bus.lock;
`else
    assign lock_w = 1'b0;
`endif

    assign is_idle  = (state_q == IDLE);
    assign is_own   = (state_q == OWN_A) || (state_q == OWN_B);
    assign cur      = (state_q == OWN_B);
    assign own_req  = cur ? bus.req_b : bus.req_a;
    assign oth_req  = cur ? bus.req_a : bus.req_b;
    assign at_max   = (cnt_q == CNT_MAX);
    assign other_st = cur ? OWN_A : OWN_B;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    // last: 0 = A was the previous owner, 1 = B
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (1'b1)
            is_idle: begin
                cnt_d = '0;
                unique case (1'b1)
                    bus.req_a && !bus.req_b: state_d = OWN_A;
                    bus.req_b && !bus.req_a: state_d = OWN_B;
                    bus.req_a && bus.req_b:
                        state_d = last_q ? OWN_A : OWN_B;
                    default: state_d = IDLE;
                endcase
            end
            is_own && !own_req: begin
                cnt_d   = '0;
                last_d  = cur;
                state_d = oth_req ? other_st : IDLE;
            end
            is_own && own_req && lock_w: begin
                cnt_d = at_max ? cnt_q : cnt_q + 1'b1;
            end
            is_own && own_req && !lock_w && at_max: begin
                cnt_d = '0;
                if (oth_req) begin
                    state_d = other_st;
                    last_d  = cur;
                end
            end
            is_own && own_req && !lock_w && !at_max: begin
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // sel tracks the next owner so it flips with the grant, holds in IDLE
    always_comb begin
        sel_d = sel_q;
        unique case (1'b1)
            state_d == OWN_A: sel_d = 1'b0;
            state_d == OWN_B: sel_d = 1'b1;
            default:          sel_d = sel_q;
        endcase
    end

    assign bus.gnt_a = (state_q == OWN_A);
    assign bus.gnt_b = (state_q == OWN_B);
    assign bus.busy  = is_own;
    assign bus.sel   = sel_q;

endmodule

// File: tb/tb_mux21_sel_arb.sv
// Bench for mux21_sel_arb: BURST_MAX=4 and BURST_MAX=1 instances
// checked against an owner/beat-count reference model.
module tb_mux21_sel_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  mux21_sel_arb_if bus4 ();
  mux21_sel_arb_if bus1 ();

  mux21_sel_arb #(.BURST_MAX(4), .CNT_W(3)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  mux21_sel_arb #(.BURST_MAX(1), .CNT_W(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  int checks = 0;
  int errors = 0;

  // owner: 0 none, 1 A, 2 B
  int owner[2];
  int used[2];
  int last[2];
  int selm[2];
  int burst[2] = '{4, 1};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = 0;
      used[i]  = 0;
      last[i]  = 2;
      selm[i]  = 0;
    end
  endtask

  task automatic step(input int i, input logic a, input logic b,
                      input logic l);
    logic mine, oth;
    if (owner[i] == 0) begin
      used[i] = 0;
      if (a && !b) owner[i] = 1;
      else if (b && !a) owner[i] = 2;
      else if (a && b) owner[i] = (last[i] == 2) ? 1 : 2;
    end else begin
      mine = (owner[i] == 1) ? a : b;
      oth  = (owner[i] == 1) ? b : a;
      if (!mine) begin
        last[i]  = owner[i];
        owner[i] = oth ? 3 - owner[i] : 0;
        used[i]  = 0;
      end else if (l) begin
        if (used[i] < burst[i] - 1) used[i]++;
      end else if (used[i] + 1 == burst[i]) begin
        used[i] = 0;
        if (oth) begin
          last[i]  = owner[i];
          owner[i] = 3 - owner[i];
        end
      end else begin
        used[i]++;
      end
    end
    if (owner[i] == 1) selm[i] = 0;
    else if (owner[i] == 2) selm[i] = 1;
  endtask

  task automatic compare();
    chk("d4.gnt_a", 32'(bus4.gnt_a), 32'(owner[0] == 1));
    chk("d4.gnt_b", 32'(bus4.gnt_b), 32'(owner[0] == 2));
    chk("d4.busy",  32'(bus4.busy),  32'(owner[0] != 0));
    chk("d4.sel",   32'(bus4.sel),   32'(selm[0]));
    chk("d1.gnt_a", 32'(bus1.gnt_a), 32'(owner[1] == 1));
    chk("d1.gnt_b", 32'(bus1.gnt_b), 32'(owner[1] == 2));
    chk("d1.busy",  32'(bus1.busy),  32'(owner[1] != 0));
    chk("d1.sel",   32'(bus1.sel),   32'(selm[1]));
  endtask

  task automatic cycle(input logic r, input logic a, input logic b,
                       input logic l);
    logic l_eff;
    @(negedge clk);
    rst_n      = r;
    bus4.req_a = a;
    bus4.req_b = b;
    bus1.req_a = a;
    bus1.req_b = b;
`ifdef MUX21_SEL_LOCK_EN
    bus4.lock = l;
    bus1.lock = l;
    l_eff     = l;
`else
    l_eff = 1'b0;
`endif
    @(posedge clk);
    if (!r) model_reset();
    else for (int i = 0; i < 2; i++) step(i, a, b, l_eff);
    #1;
    compare();
  endtask

  initial begin
    rst_n      = 1'b0;
    bus4.req_a = 1'b0;
    bus4.req_b = 1'b0;
    bus1.req_a = 1'b0;
    bus1.req_b = 1'b0;
`ifdef MUX21_SEL_LOCK_EN
    bus4.lock = 1'b0;
    bus1.lock = 1'b0;
`endif
    model_reset();

    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_busy", 32'(bus4.busy), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("first_gnt_a", 32'(bus4.gnt_a), 32'd1);

    repeat (20) cycle(1'b1, 1'b1, 1'b1, 1'b0);

    repeat (10) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      chk("a_only_gnt_a", 32'(bus4.gnt_a), 32'd1);
    end

    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("drop_b_idle", 32'(bus4.busy), 32'd0);
    chk("drop_b_sel",  32'(bus4.sel),  32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("a_after_idle", 32'(bus4.gnt_a), 32'd1);

    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (13) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      logic r, a, b, l;
      r = ($urandom_range(0, 99) != 0);
      a = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 2) == 0);
      cycle(r, a, b, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
